// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared types and helpers for the repeated-addition multiplier controller.
//   mul_state_e : controller state encoding (IDLE, LOAD, ACC, DONE)
//   W_DEFAULT   : default operand width
//   iter_limit  : watchdog limit on ACC iterations (MAX_ITER==0 -> 2**W)
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } mul_state_e;

   localparam int W_DEFAULT = 2;

   // A correct datapath never needs more than 2**W-1 accumulations, so a
   // limit of 2**W can only be reached when zero_in is stuck low.
   function automatic int iter_limit(input int w, input int max_iter);
      return (max_iter == 0) ? (1 << w) : max_iter;
   endfunction

endpackage

// File: rtl/mul_iter_cnt.sv
// -----------------------------------------------------------------------------
// mul_iter_cnt
// Watchdog iteration counter: cleared on accepted start, counts accumulate
// cycles, flags when the limit is reached and then holds.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : count one iteration
//   o_hit      : counter has reached LIMIT
// -----------------------------------------------------------------------------
module mul_iter_cnt #(
   parameter int LIMIT = 4,
   parameter int CW    = $clog2(LIMIT) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit
);

   localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_hit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_hit = (r_cnt == LIMIT_V);

endmodule

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Sequencing FSM for the shift-free repeated-addition multiplier datapath.
// Accepts an operand pair, drives the datapath strobes, waits for the B
// counter to reach zero and holds the result valid until it is accepted.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : operand handshake (ready only in IDLE)
//   op_b                     : multiplier operand, sampled for B==0 early exit
//   abort                    : ends LOAD/ACC early with the partial product
//   zero_in                  : datapath flag, B counter == 0
//   ld_a, ld_b, clr_f        : datapath load/clear strobes (transfer cycle)
//   dec_b                    : datapath B -= 1 and F += A
//   busy                     : not in IDLE
//   res_valid/res_ready      : result handshake
//   err                      : sticky watchdog error, cleared on next start
//   o_dbg_state              : current FSM state
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds with its payload until that edge.
// -----------------------------------------------------------------------------
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int W        = W_DEFAULT,
   parameter int MAX_ITER = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] op_b,
   input  logic         abort,
   input  logic         zero_in,
   output logic         ld_a,
   output logic         ld_b,
   output logic         clr_f,
   output logic         dec_b,
   output logic         busy,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         err,
   output mul_state_e   o_dbg_state
);

   localparam int LIMIT   = iter_limit(W, MAX_ITER);
   localparam int CW_ITER = $clog2(LIMIT) + 1;

   mul_state_e r_state;
   mul_state_e w_next;
   logic       r_b_zero;
   logic       r_err;
   logic       w_accept;
   logic       w_hit;
   logic       w_wd_trip;

   // rst_n gating keeps the transfer strobes and start_ready low while
   // reset is asserted, even if start_valid is already high.
   assign w_accept = (r_state == IDLE) && start_valid && rst_n;

   // Watchdog fires only when neither zero_in nor abort ended ACC first.
   assign w_wd_trip = (r_state == ACC) && !zero_in && !abort && w_hit;

   mul_iter_cnt #(
      .LIMIT (LIMIT),
      .CW    (CW_ITER)
   ) u_iter_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_accept),
      .i_en  (dec_b),
      .o_hit (w_hit)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (start_valid) w_next = LOAD;
         LOAD: w_next = (abort || r_b_zero) ? DONE : ACC;
         ACC:  if (abort || zero_in || w_hit) w_next = DONE;
         DONE: if (res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      start_ready = (r_state == IDLE) && rst_n;
      ld_a        = w_accept;
      ld_b        = w_accept;
      clr_f       = w_accept;
      // An aborting or watchdog-tripping cycle must not add another A.
      dec_b       = (r_state == ACC) && !zero_in && !abort && !w_hit;
      busy        = (r_state != IDLE);
      res_valid   = (r_state == DONE);
   end

   // B==0 is captured at transfer so LOAD can skip ACC entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b_zero <= 1'b0;
      end else if (w_accept) begin
         r_b_zero <= (op_b == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_wd_trip) begin
         r_err <= 1'b1;
      end
   end

   assign err         = r_err;
   assign o_dbg_state = r_state;

   a_no_ldb_decb: assert property (@(posedge clk) disable iff (!rst_n) !(ld_b && dec_b));

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
// Bench for mul_seq_ctrl with a small behavioural datapath (regA/regB/regF)
// that supplies zero_in and the product. Expected products are queued at
// the start handshake and compared at the result handshake.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;
   import mul_pkg::*;

   localparam int W     = 2;
   localparam int LIMIT = iter_limit(W, 0);

   // Clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         abort = 1'b0;
   logic         zero_in;
   logic         ld_a, ld_b, clr_f, dec_b;
   logic         busy, res_valid;
   logic         res_ready = 1'b0;
   logic         err;
   mul_state_e   dbg_state;

   mul_seq_ctrl #(.W(W), .MAX_ITER(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_b        (op_b),
      .abort       (abort),
      .zero_in     (zero_in),
      .ld_a        (ld_a),
      .ld_b        (ld_b),
      .clr_f       (clr_f),
      .dec_b       (dec_b),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .err         (err),
      .o_dbg_state (dbg_state)
   );

   // Behavioural datapath; broken forces zero_in low to exercise the watchdog
   logic [W-1:0]   dp_a, dp_b;
   logic [2*W-1:0] dp_f;
   logic           broken = 1'b0;

   assign zero_in = broken ? 1'b0 : (dp_b == '0);

   always @(posedge clk) begin
      if (ld_a)  dp_a <= op_a;
      if (ld_b)  dp_b <= op_b;
      if (clr_f) dp_f <= '0;
      if (dec_b) begin
         dp_b <= dp_b - 1'b1;
         dp_f <= dp_f + {{W{1'b0}}, dp_a};
      end
   end

   // Scoreboard
   int             n_tests = 0;
   int             n_fail  = 0;
   logic [2*W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One full operation: start handshake, run, optional abort after N
   // dec_b pulses, hold res_ready low for 'hold' cycles, then accept.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input int abort_after, input logic [2*W-1:0] exp_prod,
                         input int exp_lat, input int exp_dec, input logic exp_err);
      int             lat;
      int             decs;
      bit             aborted;
      logic [2*W-1:0] got_prod;
      lat = 0;
      decs = 0;
      aborted = 0;
      @(negedge clk);
      check_eq("start_ready_idle", start_ready, 1);
      op_a = a;
      op_b = b;
      start_valid = 1'b1;
      #1;
      check_eq("xfer_strobes", {ld_a, ld_b, clr_f, dec_b}, 4'b1110);
      exp_q.push_back(exp_prod);
      @(negedge clk);
      start_valid = 1'b0;
      lat = 1;
      #1;
      check_eq("err_clear_on_start", err, 0);
      check_eq("load_strobes", {ld_a, ld_b, clr_f, dec_b}, 4'b0000);
      while (!res_valid && lat < 40) begin
         if (dec_b) decs++;
         @(negedge clk);
         lat++;
         if (abort_after > 0 && decs == abort_after && !aborted) begin
            abort = 1'b1;
            aborted = 1;
         end else begin
            abort = 1'b0;
         end
         #1;
      end
      abort = 1'b0;
      check_eq("res_valid_timeout", res_valid, 1);
      check_eq("latency", lat, exp_lat);
      check_eq("dec_b_pulses", decs, exp_dec);
      check_eq("err_at_done", err, exp_err);
      check_eq("done_strobes", {ld_a, ld_b, clr_f, dec_b}, 4'b0000);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         #1;
         check_eq("res_valid_hold", res_valid, 1);
         check_eq("start_ready_in_done", start_ready, 0);
      end
      res_ready = 1'b1;
      #1;
      check_eq("busy_in_done", busy, 1);
      got_prod = dp_f;
      if (exp_q.size() == 0) begin
         check_eq("scoreboard_empty", 1, 0);
      end else begin
         check_eq("product", got_prod, exp_q.pop_front());
      end
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      check_eq("idle_after_accept", dbg_state, IDLE);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_res_valid", res_valid, 0);
      check_eq("idle_err_sticky", err, exp_err);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           rh;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_start_ready_low", start_ready, 0);
      rst_n = 1'b1;
      #1;
      check_eq("rst_state", dbg_state, IDLE);
      check_eq("rst_start_ready", start_ready, 1);
      check_eq("rst_outputs", {ld_a, ld_b, clr_f, dec_b, res_valid, err}, 6'b0);

      // Directed cases
      run_op(2'd3, 2'd2, 0, 0, 4'd6,  5, 2, 1'b0);
      run_op(2'd2, 2'd0, 0, 0, 4'd0,  2, 0, 1'b0);
      run_op(2'd3, 2'd3, 4, 0, 4'd9,  6, 3, 1'b0);
      run_op(2'd3, 2'd3, 0, 1, 4'd3,  4, 1, 1'b0);

      // Stuck-low zero flag: watchdog ends after LIMIT accumulations
      broken = 1'b1;
      run_op(2'd3, 2'd2, 0, 0, 4'(3 * LIMIT), LIMIT + 3, LIMIT, 1'b1);
      broken = 1'b0;
      run_op(2'd1, 2'd3, 0, 0, 4'd3,  6, 3, 1'b0);

      // Reset while in ACC
      @(negedge clk);
      op_a = 2'd3;
      op_b = 2'd3;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("pre_rst_in_acc", dbg_state, ACC);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_busy", busy, 0);
      check_eq("async_rst_strobes", {ld_a, ld_b, clr_f, dec_b, res_valid}, 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_ready", start_ready, 1);
      run_op(2'd1, 2'd1, 0, 0, 4'd1, 4, 1, 1'b0);

      // Random operands
      for (int k = 0; k < 8; k++) begin
         ra = W'($urandom_range(0, 3));
         rb = W'($urandom_range(0, 3));
         rh = $urandom_range(0, 2);
         run_op(ra, rb, rh, 0, 4'(ra * rb), (rb == 0) ? 2 : int'(rb) + 3, int'(rb), 1'b0);
      end

      check_eq("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
